z80_io_port_bank: RTL and testbench
===================================

Name: z80_io_port_bank

Overview:
- Parametrised Z80 I/O port decoder and register bank; successor to the single-port OUT FF decoder.
- Decodes a contiguous, aligned block of NUM_PORTS I/O addresses on A0-A7.
- Latches OUT data into per-port output registers and returns per-port input data on IN.
- Produces one-cycle per-port strobes and an optional wait-state request to the CPU. Sits between the Z80 bus interface and on-board peripherals (LEDs, switches, UART glue).

Parameters:
- BASE_ADDR, 8'hFC, first decoded port address; must be a multiple of NUM_PORTS.
- NUM_PORTS, 4, number of ports; power of two, 1 to 8.
- WAIT_CYCLES, 2, clocks n_wait is held low per decoded access; 0 disables wait insertion.
- OUT_RESET, 8'h00, reset value of every output port register.

Ports:
- clock  in  1  system clock; all logic is on the rising edge.
- n_reset  in  1  reset, synchronous, active-low.
- address  in  8  Z80 A0-A7.
- cpu_dout  in  8  data driven by the CPU during OUT.
- n_iowrite  in  1  I/O write strobe, active-low, clock-synchronous.
- n_ioread  in  1  I/O read strobe, active-low, clock-synchronous.
- cpu_din  out  8  data returned to the CPU during IN.
- din_oe  out  1  high while cpu_din must be driven onto the bus.
- n_wait  out  1  Z80 WAIT request, active-low.
- port_in  in  8*NUM_PORTS  peripheral input values; port k is bits [8k+7:8k].
- port_out  out  8*NUM_PORTS  output port registers, same packing.
- port_wr_pulse  out  NUM_PORTS  one-cycle pulse per port on write.
- port_rd_pulse  out  NUM_PORTS  one-cycle pulse per port on read.

Behaviour:
- Decode: hit = (address >= BASE_ADDR) && (address < BASE_ADDR + NUM_PORTS). idx = address - BASE_ADDR (low log2(NUM_PORTS) bits).
- Edge detect: the block registers n_iowrite and n_ioread as prev_wr and prev_rd. A start is a cycle with prev high and the current strobe low.
- Reset: prev_wr and prev_rd reset to 0. A strobe already low when reset releases must go high before it can start an access.
- Reset values:
  - port_out = OUT_RESET on all ports.
  - cpu_din = 0.
  - din_oe = 0, n_wait = 1.
  - Pulse outputs = 0.
  - FSM state = IDLE.
  - Reset mid-access aborts the access immediately.
- FSM states: IDLE, WAIT, HOLD.
  - IDLE: on a write start with hit:
    - latch idx;
    - port_out[idx] <= cpu_dout, visible the next cycle;
    - port_wr_pulse[idx] = 1 for exactly the next cycle;
    - go to WAIT if WAIT_CYCLES > 0, else HOLD.
  - IDLE: on a read start with hit:
    - latch idx;
    - cpu_din <= port_in[idx] (captured once; later port_in changes do not affect the cycle);
    - port_rd_pulse[idx] = 1 for the next cycle;
    - din_oe = 1 from the next cycle;
    - go to WAIT or HOLD as above.
  - WAIT: n_wait = 0 for exactly WAIT_CYCLES consecutive cycles, starting the cycle after the start. A down-counter loads WAIT_CYCLES at the start. When the count expires, go to HOLD with n_wait = 1.
  - HOLD: stay until n_iowrite and n_ioread are both high, then go to IDLE. din_oe drops the same cycle n_ioread is sampled high.
- Access rules:
  - Address changes after the start are ignored because idx is latched.
  - No new start is accepted outside IDLE.
  - Simultaneous write and read start is illegal on the Z80; the write takes priority and the read is ignored.
  - An access with no hit: no register change, no pulses, n_wait stays high, FSM stays in IDLE.
  - Only the addressed port changes on a write; other ports hold their values.

Test Plan:
- Reset: hold n_reset low for 3 cycles with n_iowrite low -> port_out all 8'h00, n_wait = 1, din_oe = 0. After release, no write occurs until n_iowrite goes high then low.
- Write: OUT to FE with data 8'h5A, strobe low 4 cycles -> port 2 = 8'h5A one cycle after the edge; port_wr_pulse = 4'b0100 for one cycle; n_wait low for exactly 2 cycles; ports 0, 1, 3 unchanged.
- Read: port_in port 3 = 8'hC3, IN from FF -> cpu_din = 8'hC3 with din_oe high from edge+1 until n_ioread rises; port_rd_pulse = 4'b1000 once; changing port_in mid-cycle leaves cpu_din = 8'hC3.
- Miss: OUT to FB and IN from 00 -> no port_out change, no pulses, n_wait stays 1, din_oe stays 0.
- Boundaries: back-to-back OUT FC and OUT FD separated by 1 high cycle -> both writes land. With WAIT_CYCLES = 0, n_wait is never low. An address change to FC during a held FF strobe leaves port 3 as the target.
- Mid-access reset: assert n_reset during WAIT of an OUT to FD -> next cycle n_wait = 1, port 1 = OUT_RESET, FSM in IDLE.

Source files
------------

// File: rtl/z80_io_port_bank.sv
// Z80 I/O port decoder and register bank for a contiguous, aligned block of NUM_PORTS addresses.
// Latency: port_out, strobes, cpu_din and din_oe change one clock after the strobe's falling edge is sampled.
// Backpressure: n_wait is held low for WAIT_CYCLES clocks per decoded access; new accesses wait for both strobes high.
module z80_io_port_bank #(
  parameter logic [7:0] BASE_ADDR   = 8'hFC,
  parameter int         NUM_PORTS   = 4,
  parameter int         WAIT_CYCLES = 2,
  parameter logic [7:0] OUT_RESET   = 8'h00
) (
  input  logic                     clock,
  input  logic                     n_reset,
  input  logic [7:0]               address,
  input  logic [7:0]               cpu_dout,
  input  logic                     n_iowrite,
  input  logic                     n_ioread,
  output logic [7:0]               cpu_din,
  output logic                     din_oe,
  output logic                     n_wait,
  input  logic [8*NUM_PORTS-1:0]   port_in,
  output logic [8*NUM_PORTS-1:0]   port_out,
  output logic [NUM_PORTS-1:0]     port_wr_pulse,
  output logic [NUM_PORTS-1:0]     port_rd_pulse
);

  localparam int IW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] WAIT_LOAD = CW'(WAIT_CYCLES);
  localparam logic [8:0]    ADDR_END  = {1'b0, BASE_ADDR} + 9'(NUM_PORTS);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;
  // With no wait states the access goes straight to waiting for the strobe release.
  localparam logic [1:0] S_AFTER_START = (WAIT_CYCLES > 0) ? S_WAIT : S_HOLD;

  logic [1:0]             state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   prev_wr_q, prev_wr_d;
  logic                   prev_rd_q, prev_rd_d;
  logic [8*NUM_PORTS-1:0] port_out_q, port_out_d;
  logic [7:0]             cpu_din_q, cpu_din_d;
  logic                   din_oe_q, din_oe_d;
  logic [NUM_PORTS-1:0]   wr_pulse_q, wr_pulse_d;
  logic [NUM_PORTS-1:0]   rd_pulse_q, rd_pulse_d;

  logic          hit;
  logic [IW-1:0] acc_idx;
  logic          wr_start;
  logic          rd_start;

  // Address decode; 9-bit compare so a block ending at FF does not wrap.
  assign hit      = ({1'b0, address} >= {1'b0, BASE_ADDR}) && ({1'b0, address} < ADDR_END);
  assign acc_idx  = IW'(address - BASE_ADDR);
  assign wr_start = prev_wr_q & ~n_iowrite;
  assign rd_start = prev_rd_q & ~n_ioread;

  // Next-state logic: strobe edge detect, access start, wait countdown and release.
  // The port index is consumed only in the start cycle, so address changes later in the access have no effect.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    prev_wr_d  = n_iowrite;
    prev_rd_d  = n_ioread;
    port_out_d = port_out_q;
    cpu_din_d  = cpu_din_q;
    din_oe_d   = din_oe_q;
    wr_pulse_d = '0;
    rd_pulse_d = '0;

    if (din_oe_q && n_ioread) begin
      din_oe_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (wr_start && hit) begin
          for (int k = 0; k < NUM_PORTS; k++) begin
            if (int'(acc_idx) == k) begin
              port_out_d[8*k +: 8] = cpu_dout;
              wr_pulse_d[k]        = 1'b1;
            end
          end
          cnt_d   = WAIT_LOAD;
          state_d = S_AFTER_START;
        end else if (rd_start && hit) begin
          for (int k = 0; k < NUM_PORTS; k++) begin
            if (int'(acc_idx) == k) begin
              cpu_din_d     = port_in[8*k +: 8];
              rd_pulse_d[k] = 1'b1;
            end
          end
          din_oe_d = 1'b1;
          cnt_d    = WAIT_LOAD;
          state_d  = S_AFTER_START;
        end
      end
      S_WAIT: begin
        if (cnt_q <= CW'(1)) begin
          cnt_d   = '0;
          state_d = S_HOLD;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_HOLD: begin
        if (n_iowrite && n_ioread) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers; reset also aborts any access in progress.
  always_ff @(posedge clock) begin
    if (!n_reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      prev_wr_q  <= 1'b0;
      prev_rd_q  <= 1'b0;
      port_out_q <= {NUM_PORTS{OUT_RESET}};
      cpu_din_q  <= 8'h00;
      din_oe_q   <= 1'b0;
      wr_pulse_q <= '0;
      rd_pulse_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      prev_wr_q  <= prev_wr_d;
      prev_rd_q  <= prev_rd_d;
      port_out_q <= port_out_d;
      cpu_din_q  <= cpu_din_d;
      din_oe_q   <= din_oe_d;
      wr_pulse_q <= wr_pulse_d;
      rd_pulse_q <= rd_pulse_d;
    end
  end

  assign n_wait        = (state_q != S_WAIT);
  assign cpu_din       = cpu_din_q;
  assign din_oe        = din_oe_q;
  assign port_out      = port_out_q;
  assign port_wr_pulse = wr_pulse_q;
  assign port_rd_pulse = rd_pulse_q;

endmodule

// File: tb/tb_z80_io_port_bank.sv
// Directed bench for z80_io_port_bank: default instance plus a zero-wait-state instance on shared stimulus.
// Latency: outputs are sampled 1 ns after each rising edge.
// Backpressure: n_wait low cycles are counted per access and compared with the expected count.
`timescale 1ns/1ps
module tb_z80_io_port_bank;

  logic        clock;
  logic        n_reset;
  logic [7:0]  address;
  logic [7:0]  cpu_dout;
  logic        n_iowrite;
  logic        n_ioread;
  logic [31:0] port_in;

  logic [7:0]  cpu_din,  cpu_din0;
  logic        din_oe,   din_oe0;
  logic        n_wait,   n_wait0;
  logic [31:0] port_out, port_out0;
  logic [3:0]  wr_p,     wr_p0;
  logic [3:0]  rd_p,     rd_p0;

  int n_checks = 0;
  int n_pass   = 0;
  int w0_low   = 0;

  z80_io_port_bank u_dut (
    .clock(clock), .n_reset(n_reset), .address(address), .cpu_dout(cpu_dout),
    .n_iowrite(n_iowrite), .n_ioread(n_ioread), .cpu_din(cpu_din), .din_oe(din_oe),
    .n_wait(n_wait), .port_in(port_in), .port_out(port_out),
    .port_wr_pulse(wr_p), .port_rd_pulse(rd_p)
  );

  z80_io_port_bank #(.WAIT_CYCLES(0)) u_dut0 (
    .clock(clock), .n_reset(n_reset), .address(address), .cpu_dout(cpu_dout),
    .n_iowrite(n_iowrite), .n_ioread(n_ioread), .cpu_din(cpu_din0), .din_oe(din_oe0),
    .n_wait(n_wait0), .port_in(port_in), .port_out(port_out0),
    .port_wr_pulse(wr_p0), .port_rd_pulse(rd_p0)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (n_reset && !n_wait0) w0_low++;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got running required finished");
    $fatal(1);
  end

  typedef struct {
    logic [7:0]  addr;
    logic [7:0]  dat;
    logic        wr;
    logic [3:0]  exp_wrp;
    logic [3:0]  exp_rdp;
    logic [7:0]  exp_din;
    logic        exp_oe;
    int          exp_wait;
    logic [31:0] exp_out;
  } vec_t;

  vec_t vecs [9];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h required %h", name, act, exp);
  endtask

  task automatic access(input vec_t v, input string nm);
    int wl;
    wl = 0;
    address  = v.addr;
    cpu_dout = v.dat;
    if (v.wr) n_iowrite = 1'b0;
    else      n_ioread  = 1'b0;
    tick();
    chk({nm, "_wr_pulse"}, {28'd0, wr_p}, {28'd0, v.exp_wrp});
    chk({nm, "_rd_pulse"}, {28'd0, rd_p}, {28'd0, v.exp_rdp});
    chk({nm, "_din_oe"}, {31'd0, din_oe}, {31'd0, v.exp_oe});
    if (v.exp_oe) chk({nm, "_cpu_din"}, {24'd0, cpu_din}, {24'd0, v.exp_din});
    if (!n_wait) wl++;
    tick();
    chk({nm, "_pulse_clear"}, {24'd0, wr_p, rd_p}, 32'd0);
    if (!n_wait) wl++;
    repeat (2) begin
      tick();
      if (!n_wait) wl++;
    end
    chk({nm, "_wait_cycles"}, wl, v.exp_wait);
    n_iowrite = 1'b1;
    n_ioread  = 1'b1;
    tick();
    chk({nm, "_oe_drop"}, {31'd0, din_oe}, 32'd0);
    tick();
    chk({nm, "_port_out"}, port_out, v.exp_out);
  endtask

  initial begin
    // port k = bits [8k+7:8k]: port3=C3 port2=B2 port1=A1 port0=90
    vecs[0] = '{8'hFE, 8'h5A, 1'b1, 4'b0100, 4'b0000, 8'h00, 1'b0, 2, 32'h005A_0000};
    vecs[1] = '{8'hFC, 8'h11, 1'b1, 4'b0001, 4'b0000, 8'h00, 1'b0, 2, 32'h005A_0011};
    vecs[2] = '{8'hFD, 8'h22, 1'b1, 4'b0010, 4'b0000, 8'h00, 1'b0, 2, 32'h005A_2211};
    vecs[3] = '{8'hFF, 8'h33, 1'b1, 4'b1000, 4'b0000, 8'h00, 1'b0, 2, 32'h335A_2211};
    vecs[4] = '{8'hFF, 8'h00, 1'b0, 4'b0000, 4'b1000, 8'hC3, 1'b1, 2, 32'h335A_2211};
    vecs[5] = '{8'hFC, 8'h00, 1'b0, 4'b0000, 4'b0001, 8'h90, 1'b1, 2, 32'h335A_2211};
    vecs[6] = '{8'hFB, 8'h77, 1'b1, 4'b0000, 4'b0000, 8'h00, 1'b0, 0, 32'h335A_2211};
    vecs[7] = '{8'h00, 8'h00, 1'b0, 4'b0000, 4'b0000, 8'h00, 1'b0, 0, 32'h335A_2211};
    vecs[8] = '{8'hFE, 8'hA5, 1'b1, 4'b0100, 4'b0000, 8'h00, 1'b0, 2, 32'h33A5_2211};

    port_in   = 32'hC3B2_A190;
    address   = 8'hFE;
    cpu_dout  = 8'hAA;
    n_iowrite = 1'b0;
    n_ioread  = 1'b1;
    n_reset   = 1'b0;

    // Reset held 3 cycles with the write strobe low.
    repeat (3) tick();
    chk("rst_port_out", port_out, 32'h0);
    chk("rst_n_wait", {31'd0, n_wait}, 32'd1);
    chk("rst_din_oe", {31'd0, din_oe}, 32'd0);
    chk("rst_cpu_din", {24'd0, cpu_din}, 32'd0);
    chk("rst_pulses", {24'd0, wr_p, rd_p}, 32'd0);

    // Strobe still low after release: no write until it rises and falls again.
    n_reset = 1'b1;
    repeat (3) tick();
    chk("rel_no_write", port_out, 32'h0);
    chk("rel_no_wait", {31'd0, n_wait}, 32'd1);
    n_iowrite = 1'b1;
    tick();
    n_iowrite = 1'b0;
    tick();
    chk("rel_write_lands", port_out, 32'h00AA_0000);
    n_iowrite = 1'b1;
    repeat (4) tick();
    n_reset = 1'b0;
    tick();
    n_reset = 1'b1;
    repeat (2) tick();
    chk("rerst_port_out", port_out, 32'h0);

    for (int i = 0; i < 9; i++) begin
      access(vecs[i], $sformatf("vec%0d", i));
      tick();
    end

    // Read captures port_in once; later port_in / address changes are ignored.
    address  = 8'hFF;
    n_ioread = 1'b0;
    tick();
    port_in[31:24] = 8'h5E;
    address = 8'hFC;
    repeat (3) tick();
    chk("rd_hold_din", {24'd0, cpu_din}, 32'h0000_00C3);
    chk("rd_hold_oe", {31'd0, din_oe}, 32'd1);
    n_ioread = 1'b1;
    port_in  = 32'hC3B2_A190;
    repeat (2) tick();
    chk("rd_hold_oe_off", {31'd0, din_oe}, 32'd0);

    // Back-to-back writes separated by one high cycle.
    address = 8'hFC; cpu_dout = 8'h44; n_iowrite = 1'b0;
    repeat (4) tick();
    n_iowrite = 1'b1;
    tick();
    address = 8'hFD; cpu_dout = 8'h55; n_iowrite = 1'b0;
    tick();
    chk("b2b_second_pulse", {28'd0, wr_p}, 32'h2);
    repeat (3) tick();
    n_iowrite = 1'b1;
    repeat (2) tick();
    chk("b2b_port_out", port_out, 32'h33A5_5544);

    // Address change during a held write to FF keeps port 3 as the target.
    address = 8'hFF; cpu_dout = 8'h66; n_iowrite = 1'b0;
    tick();
    address = 8'hFC; cpu_dout = 8'h99;
    repeat (3) tick();
    n_iowrite = 1'b1;
    repeat (2) tick();
    chk("addr_change_port_out", port_out, 32'h66A5_5544);

    // Reset during the wait phase of an OUT to FD.
    address = 8'hFD; cpu_dout = 8'h77; n_iowrite = 1'b0;
    tick();
    chk("mid_rst_in_wait", {31'd0, n_wait}, 32'd0);
    n_reset = 1'b0;
    tick();
    chk("mid_rst_n_wait", {31'd0, n_wait}, 32'd1);
    chk("mid_rst_port_out", port_out, 32'h0);
    n_reset   = 1'b1;
    n_iowrite = 1'b1;
    tick();
    address = 8'hFE; cpu_dout = 8'h12; n_iowrite = 1'b0;
    tick();
    chk("post_rst_idle_pulse", {28'd0, wr_p}, 32'h4);
    chk("post_rst_wait", {31'd0, n_wait}, 32'd0);
    repeat (3) tick();
    n_iowrite = 1'b1;
    repeat (2) tick();
    chk("post_rst_port_out", port_out, 32'h0012_0000);

    // Zero-wait instance: never asserts n_wait, same register contents.
    chk("nowait_never_low", w0_low, 0);
    chk("nowait_port_out", port_out0, 32'h0012_0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
